// File: rtl/lanes_seq.sv
// Sequencer that streams a VLEN-element vector op through the 4-lane ALU one
// group at a time, holding each group for the op latency and gathering results.
module lanes_seq #(
  parameter int VLEN    = 16,
  parameter int INT_LAT = 1,
  parameter int FP_LAT  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           func_i,
  input  logic [VLEN*32-1:0]   vec_a,
  input  logic [VLEN*32-1:0]   vec_b,
  output logic [31:0]          dataA0,
  output logic [31:0]          dataA1,
  output logic [31:0]          dataA2,
  output logic [31:0]          dataA3,
  output logic [31:0]          dataB0,
  output logic [31:0]          dataB1,
  output logic [31:0]          dataB2,
  output logic [31:0]          dataB3,
  output logic [1:0]           func,
  input  logic [31:0]          result0,
  input  logic [31:0]          result1,
  input  logic [31:0]          result2,
  input  logic [31:0]          result3,
  output logic [VLEN*32-1:0]   vec_res,
  output logic                 busy,
  output logic                 done
);

  localparam int G      = VLEN / 4;
  localparam int IW     = $clog2(VLEN);
  localparam int GW     = (G > 1) ? $clog2(G) : 1;
  localparam int MAXLAT = (FP_LAT > INT_LAT) ? FP_LAT : INT_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [VLEN*32-1:0]  a_q, b_q;
  logic [GW-1:0]       g;
  logic [CW-1:0]       cnt, lat_m1;
  logic [IW-1:0]       base_cur, base_nxt;
  logic                accept;

  function automatic logic [31:0] elem(input logic [VLEN*32-1:0] v,
                                       input logic [IW-1:0] base, input int k);
    return v[(32'(base) + k) * 32 +: 32];
  endfunction

  always_comb begin
    lat_m1   = func[0] ? CW'(FP_LAT - 1) : CW'(INT_LAT - 1);
    base_cur = IW'(g) << 2;
    base_nxt = base_cur + IW'(4);
    accept   = (state == IDLE) && start;
  end

  // NOTE: operand copies are pure datapath storage and are always written before
  // being read, so they carry no reset; only control and visible outputs do.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      a_q <= vec_a;
      b_q <= vec_b;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all updates see
  // pre-edge values, e.g. a capture and the group advance on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      g       <= '0;
      cnt     <= '0;
      func    <= '0;
      vec_res <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dataA0  <= '0; dataA1 <= '0; dataA2 <= '0; dataA3 <= '0;
      dataB0  <= '0; dataB1 <= '0; dataB2 <= '0; dataB3 <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            func    <= func_i;
            vec_res <= '0;
            g       <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            dataA0  <= vec_a[0 +: 32];  dataA1 <= vec_a[32 +: 32];
            dataA2  <= vec_a[64 +: 32]; dataA3 <= vec_a[96 +: 32];
            dataB0  <= vec_b[0 +: 32];  dataB1 <= vec_b[32 +: 32];
            dataB2  <= vec_b[64 +: 32]; dataB3 <= vec_b[96 +: 32];
            state   <= RUN;
          end
        end
        RUN: begin
          if (cnt == lat_m1) begin
            cnt <= '0;
            vec_res[(32'(base_cur) + 0) * 32 +: 32] <= result0;
            vec_res[(32'(base_cur) + 1) * 32 +: 32] <= result1;
            vec_res[(32'(base_cur) + 2) * 32 +: 32] <= result2;
            vec_res[(32'(base_cur) + 3) * 32 +: 32] <= result3;
            if (g == GW'(G - 1)) begin
              // Final group: lanes are parked at zero, func stays for observers.
              state  <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              dataA0 <= '0; dataA1 <= '0; dataA2 <= '0; dataA3 <= '0;
              dataB0 <= '0; dataB1 <= '0; dataB2 <= '0; dataB3 <= '0;
            end else begin
              g      <= g + 1'b1;
              dataA0 <= elem(a_q, base_nxt, 0); dataA1 <= elem(a_q, base_nxt, 1);
              dataA2 <= elem(a_q, base_nxt, 2); dataA3 <= elem(a_q, base_nxt, 3);
              dataB0 <= elem(b_q, base_nxt, 0); dataB1 <= elem(b_q, base_nxt, 1);
              dataB2 <= elem(b_q, base_nxt, 2); dataB3 <= elem(b_q, base_nxt, 3);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lanes_seq.sv
// Bench for lanes_seq: a behavioural lane stub drives result0..3, and a
// cycle-level schedule model checks lane operands, status and the result vector.
module tb_lanes_seq;

  localparam int VLEN    = 16;
  localparam int G       = VLEN / 4;
  localparam int INT_LAT = 1;
  localparam int FP_LAT  = 12;

  logic               clk, rst, start;
  logic [1:0]         func_i, func;
  logic [VLEN*32-1:0] vec_a, vec_b, vec_res;
  logic [31:0]        dataA0, dataA1, dataA2, dataA3;
  logic [31:0]        dataB0, dataB1, dataB2, dataB3;
  logic [31:0]        result0, result1, result2, result3;
  logic               busy, done;

  lanes_seq #(.VLEN(VLEN), .INT_LAT(INT_LAT), .FP_LAT(FP_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .func_i(func_i),
    .vec_a(vec_a), .vec_b(vec_b),
    .dataA0(dataA0), .dataA1(dataA1), .dataA2(dataA2), .dataA3(dataA3),
    .dataB0(dataB0), .dataB1(dataB1), .dataB2(dataB2), .dataB3(dataB3),
    .func(func),
    .result0(result0), .result1(result1), .result2(result2), .result3(result3),
    .vec_res(vec_res), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the lanes block: integer ops exact, fp ops exact for the
  // known operand pairs and a distinct deterministic mix otherwise.
  function automatic logic [31:0] lane_f(input logic [1:0] f, input logic [31:0] a, b);
    case (f)
      2'b00:   return a + b;
      2'b10:   return a * b;
      2'b01:   return (a == 32'h41A9999A && b == 32'h41BB3333) ? 32'h42326666
                      : a ^ {b[15:0], b[31:16]};
      default: return (a == 32'h40000000 && b == 32'h40400000) ? 32'h40C00000
                      : a ^ b ^ 32'h5A5A5A5A;
    endcase
  endfunction

  assign result0 = lane_f(func, dataA0, dataB0);
  assign result1 = lane_f(func, dataA1, dataB1);
  assign result2 = lane_f(func, dataA2, dataB2);
  assign result3 = lane_f(func, dataA3, dataB3);

  int tests = 0;
  int fails = 0;
  logic [31:0] ea[VLEN], eb[VLEN], er[VLEN];

  function automatic logic [VLEN*32-1:0] pack(input logic [31:0] e[VLEN]);
    logic [VLEN*32-1:0] v;
    for (int i = 0; i < VLEN; i++) v[i*32 +: 32] = e[i];
    return v;
  endfunction

  // Launches one op at the current negedge, then follows it cycle by cycle
  // until the done cycle. start is held for hold_cycles further edges.
  task automatic run_op(input logic [1:0] f, input int hold_cycles, input string name);
    int lat;
    int grp;
    logic [127:0] obs_a, exp_a, obs_b, exp_b;
    lat    = f[0] ? FP_LAT : INT_LAT;
    vec_a  = pack(ea);
    vec_b  = pack(eb);
    func_i = f;
    start  = 1'b1;
    for (int t = 0; t < G * lat; t++) begin
      @(negedge clk);
      start  = (t < hold_cycles);
      vec_a  = ~vec_a;
      vec_b  = {vec_b[VLEN*32-2:0], ~vec_b[VLEN*32-1]};
      func_i = ~f;
      grp    = t / lat;
      obs_a  = {dataA3, dataA2, dataA1, dataA0};
      obs_b  = {dataB3, dataB2, dataB1, dataB0};
      exp_a  = {ea[4*grp+3], ea[4*grp+2], ea[4*grp+1], ea[4*grp]};
      exp_b  = {eb[4*grp+3], eb[4*grp+2], eb[4*grp+1], eb[4*grp]};
      tests++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        fails++;
        $display("FAIL %s lanes t=%0d: A=%h B=%h, required A=%h B=%h",
                 name, t, obs_a, obs_b, exp_a, exp_b);
      end
      tests++;
      if ({busy, done, func} !== {2'b10, f}) begin
        fails++;
        $display("FAIL %s status t=%0d: busy/done/func=%b, required %b",
                 name, t, {busy, done, func}, {2'b10, f});
      end
      if (t == 0) begin
        tests++;
        if (vec_res !== '0) begin
          fails++;
          $display("FAIL %s vec_res cleared on accept: %h", name, vec_res);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({busy, done, func} !== {2'b01, f}) begin
      fails++;
      $display("FAIL %s done cycle: busy/done/func=%b, required %b",
               name, {busy, done, func}, {2'b01, f});
    end
    tests++;
    if ({dataA3, dataA2, dataA1, dataA0, dataB3, dataB2, dataB1, dataB0} !== '0) begin
      fails++;
      $display("FAIL %s lanes zero at done: A0=%h B0=%h", name, dataA0, dataB0);
    end
    tests++;
    if (vec_res !== pack(er)) begin
      fails++;
      $display("FAIL %s vec_res: %h, required %h", name, vec_res, pack(er));
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || vec_res !== pack(er)) begin
        fails++;
        $display("FAIL %s idle c=%0d: busy=%b done=%b vec_res=%h, required 0 0 %h",
                 name, c, busy, done, vec_res, pack(er));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; func_i = 2'b11;
    vec_a = '1; vec_b = '1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, func} !== '0 || vec_res !== '0 ||
        {dataA0, dataA1, dataA2, dataA3, dataB0, dataB1, dataB2, dataB3} !== '0) begin
      fails++;
      $display("FAIL reset state: busy=%b done=%b func=%b vec_res=%h A0=%h, required all 0",
               busy, done, func, vec_res, dataA0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_int_add();
    for (int i = 0; i < VLEN; i++) begin ea[i] = i; eb[i] = 100; er[i] = 100 + i; end
    run_op(2'b00, 0, "int_add");
    check_idle("int_add", 3);
  endtask

  task automatic test_fp_add();
    for (int i = 0; i < VLEN; i++) begin
      ea[i] = 32'h41A9999A; eb[i] = 32'h41BB3333; er[i] = 32'h42326666;
    end
    run_op(2'b01, 0, "fp_add");
    check_idle("fp_add", 2);
  endtask

  task automatic test_fp_mul();
    for (int i = 0; i < VLEN; i++) begin
      ea[i] = 32'h40000000; eb[i] = 32'h40400000; er[i] = 32'h40C00000;
    end
    run_op(2'b11, 0, "fp_mul");
    check_idle("fp_mul", 2);
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < VLEN; i++) begin
      ea[i] = 32'h41A9999A; eb[i] = 32'h41BB3333; er[i] = 32'h42326666;
    end
    ea[5] = 32'h00000003; eb[5] = 32'h00000004; er[5] = lane_f(2'b01, ea[5], eb[5]);
    run_op(2'b01, 10, "start_busy");
    check_idle("start_busy", 60);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < VLEN; i++) begin ea[i] = i; eb[i] = 100; er[i] = 100 + i; end
    run_op(2'b00, 0, "b2b_first");
    for (int i = 0; i < VLEN; i++) begin ea[i] = 7; eb[i] = 6; er[i] = 42; end
    run_op(2'b10, 0, "b2b_second");
    check_idle("b2b_second", 2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < VLEN; i++) begin
      ea[i] = $urandom; eb[i] = $urandom; er[i] = '0;
    end
    vec_a = pack(ea); vec_b = pack(eb); func_i = 2'b01; start = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 19) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, done, func} !== '0 || vec_res !== '0 ||
        {dataA0, dataA1, dataA2, dataA3, dataB0, dataB1, dataB2, dataB3} !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b func=%b vec_res=%h A0=%h, required all 0",
               busy, done, func, vec_res, dataA0);
    end
    check_idle("reset_mid", 40);
    for (int i = 0; i < VLEN; i++) er[i] = lane_f(2'b01, ea[i], eb[i]);
    run_op(2'b01, 0, "after_reset");
    check_idle("after_reset", 2);
  endtask

  task automatic test_random();
    logic [1:0] f;
    for (int n = 0; n < 6; n++) begin
      f = 2'($urandom_range(0, 3));
      for (int i = 0; i < VLEN; i++) begin
        ea[i] = $urandom; eb[i] = $urandom; er[i] = lane_f(f, ea[i], eb[i]);
      end
      run_op(f, (n == 2) ? 3 : 0, "random");
      if (n % 2 == 1) check_idle("random", 1);
    end
    check_idle("random", 2);
  endtask

  initial begin
    test_reset();
    test_int_add();
    test_fp_add();
    test_fp_mul();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
